sha256_msg_schedule: RTL

//  Message-schedule stage that sits directly downstream of the message packer and

---
 rtl/sha256_msg_schedule.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block and emits W0..W63 one word per
// valid/ready transfer, using a 16-entry sliding window instead of the full array.
module sha256_msg_schedule #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int ROUNDS      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] MP_data_in,
    input  logic                  MP_dv_in,
    input  logic                  W_ready_in,
    output logic [DATA_WIDTH-1:0] W_data_out,
    output logic                  W_valid_out,
    output logic [5:0]            W_index_out,
    output logic                  block_done_out,
    output logic                  busy_out,
    output logic                  overrun_out
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("sha256_msg_schedule: only DATA_WIDTH=32 is supported");
    end

    localparam int CNT_W = $clog2(BLOCK_WORDS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [5:0]       LAST_T    = 6'(ROUNDS - 1);
    localparam logic [5:0]       FILL_T    = 6'(ROUNDS - BLOCK_WORDS);

    logic [1:0]       state;
    logic [CNT_W-1:0] load_cnt;
    logic [5:0]       t;
    logic [31:0]      win [BLOCK_WORDS];
    logic [31:0]      expand;
    logic [31:0]      shift_word;
    logic             xfer;
    logic             shift_en;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign xfer     = (state == S_EMIT) && W_ready_in;
    assign shift_en = xfer || (((state == S_IDLE) || (state == S_LOAD)) && MP_dv_in);
    assign expand   = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    // The last 16 words need no successors, so their shift-in slot is zero-filled.
    always_comb begin
        shift_word = '0;
        if (state == S_EMIT) begin
            if (t < FILL_T)
                shift_word = expand;
        end else begin
            shift_word = MP_data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            load_cnt    <= '0;
            t           <= '0;
            overrun_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MP_dv_in) begin
                        load_cnt <= CNT_W'(1);
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (MP_dv_in) begin
                        if (load_cnt == LAST_LOAD) begin
                            load_cnt <= '0;
                            t        <= '0;
                            state    <= S_EMIT;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (MP_dv_in)
                        overrun_out <= 1'b1;
                    if (W_ready_in) begin
                        if (t == LAST_T)
                            state <= S_DONE;
                        else
                            t <= t + 1'b1;
                    end
                end
                S_DONE: begin
                    if (MP_dv_in)
                        overrun_out <= 1'b1;
                    t     <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    load_cnt <= '0;
                    t        <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BLOCK_WORDS; i++)
                win[i] <= '0;
        end else if (state == S_DONE) begin
            for (int unsigned i = 0; i < BLOCK_WORDS; i++)
                win[i] <= '0;
        end else if (shift_en) begin
            for (int unsigned i = 0; i < BLOCK_WORDS - 1; i++)
                win[i] <= win[i+1];
            win[BLOCK_WORDS-1] <= shift_word;
        end
    end

    assign W_valid_out    = (state == S_EMIT);
    assign W_data_out     = W_valid_out ? win[0] : '0;
    assign W_index_out    = W_valid_out ? t : '0;
    assign block_done_out = (state == S_DONE);
    assign busy_out       = (state != S_IDLE);

endmodule
